spi_word_rx: RTL and testbench

- SPI slave front end of the chip. Receives 16-bit instruction/data words on nCS/SCK/MOSI (mode 0, MSB first) and synchronises them into the core clock domain.
- Tags each word with an auto-incrementing load address and buffers it in a small FIFO.
- Presents words to the downstream loader / CPU instruction port over a valid/ready handshake.

---
 rtl/spi_word_rx_if.sv | 25 ++
 rtl/spi_word_rx.sv | 134 +++++++++++++
 tb/tb_spi_word_rx.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_word_rx_if.sv
// Bus bundle for the SPI word receiver: SPI pins on one side, valid/ready word port plus status on the other.
// The slave modport is the receiver's view; master is whoever drives the pins and consumes words.
interface spi_word_rx_if #(
    parameter int AW = 12
);
    logic          nCS;
    logic          SCK;
    logic          MOSI;
    logic [15:0]   out_data;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready;
    logic          overrun;
    logic          short_frame;

    modport slave (
        input  nCS, SCK, MOSI, out_ready,
        output out_data, out_addr, out_valid, overrun, short_frame
    );

    modport master (
        output nCS, SCK, MOSI, out_ready,
        input  out_data, out_addr, out_valid, overrun, short_frame
    );
endinterface

// File: rtl/spi_word_rx.sv
// SPI mode-0 slave that assembles 16-bit words, tags each with a per-frame load address,
// and hands them to the core through a small show-ahead FIFO with valid/ready.
module spi_word_rx #(
    parameter int DEPTH = 4,
    parameter int AW    = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_word_rx_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 16 + AW;
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    // Index 0 is the first flop; nCS idles high so a bus already low after reset still yields a fresh fall.
    logic [2:0] ncsSync_q;
    logic [2:0] sckSync_q;
    logic [1:0] mosiSync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncsSync_q  <= 3'b111;
            sckSync_q  <= 3'b000;
            mosiSync_q <= 2'b00;
        end else begin
            ncsSync_q  <= {ncsSync_q[1:0], bus.nCS};
            sckSync_q  <= {sckSync_q[1:0], bus.SCK};
            mosiSync_q <= {mosiSync_q[0], bus.MOSI};
        end
    end

    logic sckRise;
    logic ncsFall;
    logic ncsRise;
    logic mosiBit;

    assign sckRise = sckSync_q[1] & ~sckSync_q[2];
    assign ncsFall = ~ncsSync_q[1] & ncsSync_q[2];
    assign ncsRise = ncsSync_q[1] & ~ncsSync_q[2];
    assign mosiBit = mosiSync_q[1];

    logic [3:0]    bitCnt_q, bitCnt_d;
    logic [15:0]   shreg_q, shreg_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          shortFrame_q, shortFrame_d;
    logic [3:0]    cntBase;
    logic [AW-1:0] addrBase;
    logic          push;
    logic [EW-1:0] entryIn;

    // A frame start and the first SCK rise can land in the same cycle, so shifting works from the post-restart base.
    always_comb begin
        cntBase      = ncsFall ? 4'd0 : bitCnt_q;
        addrBase     = ncsFall ? '0 : addr_q;
        bitCnt_d     = cntBase;
        shreg_d      = shreg_q;
        addr_d       = addrBase;
        shortFrame_d = 1'b0;
        push         = 1'b0;
        if (sckRise && !ncsSync_q[1]) begin
            shreg_d  = {shreg_q[14:0], mosiBit};
            bitCnt_d = cntBase + 4'd1;
            if (cntBase == 4'd15) begin
                push   = 1'b1;
                addr_d = addrBase + AW'(1);
            end
        end
        if (ncsRise) begin
            shortFrame_d = (bitCnt_q != 4'd0);
            bitCnt_d     = 4'd0;
        end
        entryIn = {shreg_d, addrBase};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitCnt_q     <= 4'd0;
            shreg_q      <= 16'd0;
            addr_q       <= '0;
            shortFrame_q <= 1'b0;
        end else begin
            bitCnt_q     <= bitCnt_d;
            shreg_q      <= shreg_d;
            addr_q       <= addr_d;
            shortFrame_q <= shortFrame_d;
        end
    end

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [PW:0]   count_q;
    logic          overrun_q;
    logic          pop;
    logic          pushOk;

    // A push into a full FIFO still succeeds when the head leaves in the same cycle.
    assign pop    = (count_q != '0) & bus.out_ready;
    assign pushOk = push & ((count_q != FULL_COUNT) | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (pushOk) begin
                mem_q[wrPtr_q] <= entryIn;
                wrPtr_q        <= wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            case ({pushOk, pop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (push && !pushOk) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.out_valid   = (count_q != '0);
    assign bus.out_data    = mem_q[rdPtr_q][EW-1:AW];
    assign bus.out_addr    = mem_q[rdPtr_q][AW-1:0];
    assign bus.overrun     = overrun_q;
    assign bus.short_frame = shortFrame_q;
endmodule

// File: tb/tb_spi_word_rx.sv
// Directed bench for spi_word_rx: a default-width receiver plus an AW=4 twin on the same pins for address wrap.
module tb_spi_word_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #20 clk = ~clk;

    spi_word_rx_if #(.AW(12)) ifc ();
    spi_word_rx_if #(.AW(4))  ifc4 ();

    assign ifc4.nCS       = ifc.nCS;
    assign ifc4.SCK       = ifc.SCK;
    assign ifc4.MOSI      = ifc.MOSI;
    assign ifc4.out_ready = ifc.out_ready;

    spi_word_rx #(.DEPTH(4), .AW(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    spi_word_rx #(.DEPTH(4), .AW(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc4)
    );

    int vectors = 0;
    int miscompares = 0;
    int shortPulses = 0;
    logic [31:0] rxQ[$];
    logic [31:0] rxQ4[$];
    logic [31:0] expQ[$];

    // Ready only changes 5 ns after a rising edge, so the falling edge sees what the next rising edge will use.
    always @(negedge clk) begin
        if (ifc.out_valid && ifc.out_ready) rxQ.push_back({ifc.out_data, 16'(ifc.out_addr)});
        if (ifc4.out_valid && ifc4.out_ready) rxQ4.push_back({ifc4.out_data, 16'(ifc4.out_addr)});
        if (ifc.short_frame) shortPulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic expectWord(input logic [15:0] data, input logic [15:0] addr);
        expQ.push_back({data, addr});
    endtask

    task automatic checkRx(input string tag, input bit useDut4);
        logic [31:0] got[$];
        logic [31:0] obs;
        got = useDut4 ? rxQ4 : rxQ;
        checkOutput({tag, " count"}, 32'(got.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            obs = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
            checkOutput($sformatf("%s[%0d]", tag, i), obs, expQ[i]);
        end
        expQ.delete();
        rxQ.delete();
        rxQ4.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic setReady(input logic v);
        @(posedge clk);
        #5;
        ifc.out_ready = v;
    endtask

    task automatic sendBit(input logic b);
        ifc.MOSI = b;
        tick();
        tick();
        ifc.SCK = 1'b1;
        tick();
        tick();
        ifc.SCK = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) sendBit(w[i]);
    endtask

    task automatic startFrame();
        ifc.nCS = 1'b0;
        tick();
        tick();
    endtask

    task automatic endFrame();
        tick();
        tick();
        ifc.nCS = 1'b1;
        repeat (6) tick();
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [15:0] w;
        ifc.nCS = 1'b1;
        ifc.SCK = 1'b0;
        ifc.MOSI = 1'b0;
        ifc.out_ready = 1'b0;
        repeat (2) tick();
        checkOutput("reset valid", 32'(ifc.out_valid), 32'd0);
        checkOutput("reset data", 32'(ifc.out_data), 32'd0);
        checkOutput("reset addr", 32'(ifc.out_addr), 32'd0);
        checkOutput("reset overrun", 32'(ifc.overrun), 32'd0);
        checkOutput("reset short", 32'(ifc.short_frame), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] single frame, three words");
        setReady(1'b1);
        startFrame();
        applyStimulus(16'h8003);
        applyStimulus(16'h8101);
        applyStimulus(16'h0dc0);
        endFrame();
        expectWord(16'h8003, 16'd0);
        expectWord(16'h8101, 16'd1);
        expectWord(16'h0dc0, 16'd2);
        checkRx("frame", 1'b0);
        checkOutput("frame overrun", 32'(ifc.overrun), 32'd0);
        checkOutput("frame short pulses", 32'(shortPulses), 32'd0);

        $display("[TB] backpressure and overrun");
        setReady(1'b0);
        startFrame();
        for (int k = 1; k <= 5; k++) applyStimulus(16'h8000 + 16'(k));
        endFrame();
        checkOutput("bp valid", 32'(ifc.out_valid), 32'd1);
        checkOutput("bp head data", 32'(ifc.out_data), 32'h8001);
        checkOutput("bp head addr", 32'(ifc.out_addr), 32'd0);
        checkOutput("bp overrun", 32'(ifc.overrun), 32'd1);
        repeat (5) tick();
        checkOutput("bp hold data", 32'(ifc.out_data), 32'h8001);
        setReady(1'b1);
        repeat (8) tick();
        for (int k = 1; k <= 4; k++) expectWord(16'h8000 + 16'(k), 16'(k - 1));
        checkRx("drain", 1'b0);
        checkOutput("drain valid", 32'(ifc.out_valid), 32'd0);

        $display("[TB] short frame");
        startFrame();
        for (int i = 0; i < 10; i++) sendBit(i[0]);
        endFrame();
        checkOutput("short pulses", 32'(shortPulses), 32'd1);
        checkOutput("short no push", 32'(rxQ.size()), 32'd0);
        startFrame();
        applyStimulus(16'h4005);
        endFrame();
        expectWord(16'h4005, 16'd0);
        checkRx("after short", 1'b0);
        checkOutput("overrun sticky", 32'(ifc.overrun), 32'd1);

        $display("[TB] two frames");
        startFrame();
        applyStimulus(16'h1234);
        applyStimulus(16'habcd);
        endFrame();
        startFrame();
        applyStimulus(16'h5555);
        endFrame();
        expectWord(16'h1234, 16'd0);
        expectWord(16'habcd, 16'd1);
        expectWord(16'h5555, 16'd0);
        checkRx("two frames", 1'b0);

        $display("[TB] latency and concurrent push/pop when full");
        setReady(1'b0);
        applyReset();
        startFrame();
        w = 16'ha001;
        for (int i = 15; i >= 1; i--) sendBit(w[i]);
        ifc.MOSI = w[0];
        tick();
        tick();
        ifc.SCK = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #5;
        checkOutput("latency edge1 valid", 32'(ifc.out_valid), 32'd0);
        @(posedge clk);
        #5;
        checkOutput("latency edge2 valid", 32'(ifc.out_valid), 32'd1);
        tick();
        ifc.SCK = 1'b0;
        applyStimulus(16'ha002);
        applyStimulus(16'ha003);
        applyStimulus(16'ha004);
        w = 16'ha005;
        for (int i = 15; i >= 1; i--) sendBit(w[i]);
        ifc.MOSI = w[0];
        tick();
        tick();
        ifc.SCK = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #5;
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #5;
        ifc.out_ready = 1'b0;
        tick();
        ifc.SCK = 1'b0;
        endFrame();
        checkOutput("full pop overrun", 32'(ifc.overrun), 32'd0);
        checkOutput("full pop head data", 32'(ifc.out_data), 32'ha002);
        checkOutput("full pop head addr", 32'(ifc.out_addr), 32'd1);
        expectWord(16'ha001, 16'd0);
        checkRx("full pop popped", 1'b0);
        setReady(1'b1);
        repeat (8) tick();
        expectWord(16'ha002, 16'd1);
        expectWord(16'ha003, 16'd2);
        expectWord(16'ha004, 16'd3);
        expectWord(16'ha005, 16'd4);
        checkRx("full pop drain", 1'b0);

        $display("[TB] reset mid-word");
        setReady(1'b0);
        startFrame();
        applyStimulus(16'h1111);
        w = 16'h600a;
        for (int i = 15; i >= 8; i--) sendBit(w[i]);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset valid", 32'(ifc.out_valid), 32'd0);
        checkOutput("midreset data", 32'(ifc.out_data), 32'd0);
        checkOutput("midreset addr", 32'(ifc.out_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        ifc.nCS = 1'b1;
        repeat (4) tick();
        setReady(1'b1);
        startFrame();
        applyStimulus(16'h09c0);
        endFrame();
        expectWord(16'h09c0, 16'd0);
        checkRx("after midreset", 1'b0);

        $display("[TB] address wrap on AW=4 instance");
        applyReset();
        startFrame();
        for (int k = 0; k < 17; k++) applyStimulus(16'hc000 + 16'(k));
        endFrame();
        for (int k = 0; k < 17; k++) expectWord(16'hc000 + 16'(k), 16'(k % 16));
        checkRx("wrap", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
